// File: rtl/image_stream_reader.sv
// image_stream_reader
//   Reads a finished frame out of the image RAM in raster order. It uses the
//   RAM's read port, which has a fixed latency of one cycle. Returning data
//   lands in a 2-entry FIFO. The FIFO drives a valid/ready pixel stream that
//   carries end-of-line and end-of-frame markers.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous, active-high reset
//   frame_ready  in   pulse: the RAM holds a complete frame
//   ram_addr     out  RAM read address (0 when no read is issued)
//   ram_re       out  read enable; ram_rd_data is valid one cycle later
//   ram_rd_data  in   RAM read data
//   pix_data     out  pixel (0 whenever pix_valid is low)
//   pix_valid    out  pixel available
//   pix_ready    in   sink accepts; a transfer is pix_valid & pix_ready
//   pix_eol      out  current pixel is the last one of its line
//   pix_eof      out  current pixel is the last one of the frame
//   busy         out  high from frame start until the last transfer
//   done         out  1-cycle pulse in the cycle after the final transfer
module image_stream_reader #(
    parameter int IMAGE_WIDTH             = 320,
    parameter int IMAGE_HEIGHT            = 240,
    parameter int PIXEL_WIDTH             = 8,
    parameter int IMAGE_RAM_ADDRESS_WIDTH = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               frame_ready,
    output logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] ram_addr,
    output logic                               ram_re,
    input  logic [PIXEL_WIDTH-1:0]             ram_rd_data,
    output logic [PIXEL_WIDTH-1:0]             pix_data,
    output logic                               pix_valid,
    input  logic                               pix_ready,
    output logic                               pix_eol,
    output logic                               pix_eof,
    output logic                               busy,
    output logic                               done
);

    localparam int AW         = IMAGE_RAM_ADDRESS_WIDTH;
    localparam int NUM_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int COL_W      = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int ROW_W      = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    localparam logic [AW-1:0]    LAST_ADDR = AW'(NUM_PIXELS - 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [AW-1:0]    rd_addr_reg, rd_addr_next;
    logic             pending_reg, pending_next;
    logic             done_reg, done_next;
    logic             inflight_reg;
    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;

    // 2-entry skid FIFO
    logic [PIXEL_WIDTH-1:0] mem_reg [0:1];
    logic                   wr_ptr_reg;
    logic                   rd_ptr_reg;
    logic [1:0]             count_reg;

    logic       push;
    logic       pop;
    logic [2:0] occupancy;
    logic       credit_ok;

    assign push      = inflight_reg;
    assign pix_valid = (count_reg != 2'd0);
    assign pop       = pix_valid & pix_ready;

    // A read may be issued only if it cannot overflow the FIFO. That is, the
    // FIFO entries still held after this cycle's pop, plus the read already
    // in flight, must leave room for one more.
    assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign credit_ok = (occupancy < 3'd2);

    assign pix_data = pix_valid ? mem_reg[rd_ptr_reg] : '0;
    assign pix_eol  = pix_valid & (col_reg == LAST_COL);
    assign pix_eof  = pix_eol & (row_reg == LAST_ROW);
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign ram_addr = ram_re ? rd_addr_reg : '0;

    always_comb begin
        state_next   = state_reg;
        rd_addr_next = rd_addr_reg;
        // A frame request that arrives while a frame is running is remembered.
        // Repeated requests collapse into a single pending frame.
        pending_next = pending_reg | (frame_ready & (state_reg != IDLE));
        done_next    = 1'b0;
        ram_re       = 1'b0;
        case (state_reg)
            IDLE: begin
                rd_addr_next = '0;
                if (frame_ready || pending_reg) begin
                    state_next   = STREAM;
                    pending_next = 1'b0;
                end
            end
            STREAM: begin
                if (credit_ok) begin
                    ram_re       = 1'b1;
                    rd_addr_next = rd_addr_reg + 1'b1;
                    if (rd_addr_reg == LAST_ADDR) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && pix_eof) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            rd_addr_reg  <= '0;
            pending_reg  <= 1'b0;
            done_reg     <= 1'b0;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rd_addr_reg  <= rd_addr_next;
            pending_reg  <= pending_next;
            done_reg     <= done_next;
            inflight_reg <= ram_re;
        end
    end

    // FIFO bookkeeping. Clearing inflight_reg on reset means that RAM data
    // still on its way back when reset hits is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    // Data storage needs no reset because pix_data is gated by pix_valid.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= ram_rd_data;
                end
            end
        end
    endgenerate

    // Raster position of the pixel at the head of the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (pop) begin
            if (pix_eof) begin
                col_reg <= '0;
                row_reg <= '0;
            end else if (pix_eol) begin
                col_reg <= '0;
                row_reg <= row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

endmodule
